// File: rtl/seq_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_pattern_gen: serial pattern transmitter, MSB-first, with repeat count |
// | Optional SEQ_GAP_EN inserts one idle cycle between repetitions. Rev 1.0   |
// +--------------------------------------------------------------------------+
module seq_pattern_gen #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             ready,
  output logic             x,
  output logic             x_vld,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(W);
  localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SEQ_GAP_EN
  localparam logic [1:0] S_GAP   = 2'd2;
`endif

  logic [1:0]       state_q,   state_d;
  logic [W-1:0]     pattern_q, pattern_d;
  logic [CNT_W-1:0] reps_q,    reps_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             x_q,       x_d;
  logic             x_vld_q,   x_vld_d;
  logic             frame_q,   frame_d;
  logic             done_q,    done_d;
  logic [BIT_W-1:0] next_idx;

  assign next_idx = bit_idx_q - BIT_W'(1);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    reps_d    = reps_q;
    bit_idx_d = bit_idx_q;
    x_d       = x_q;
    x_vld_d   = x_vld_q;
    frame_d   = frame_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d = pattern;
          reps_d    = reps;
          if (reps != '0) begin
            state_d   = S_SHIFT;
            bit_idx_d = MSB_IDX;
            x_d       = pattern[W-1];
            x_vld_d   = 1'b1;
            frame_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (x_vld_q && ready) begin
          if (bit_idx_q != '0) begin
            bit_idx_d = next_idx;
            x_d       = pattern_q[next_idx];
            frame_d   = 1'b0;
          end else begin
            // End of a repetition: the remaining-count reaching zero ends the frame.
            reps_d    = reps_q - CNT_W'(1);
            bit_idx_d = MSB_IDX;
            if (reps_q == CNT_W'(1)) begin
              state_d = S_IDLE;
              x_d     = 1'b0;
              x_vld_d = 1'b0;
              frame_d = 1'b0;
              done_d  = 1'b1;
            end else begin
`ifdef SEQ_GAP_EN
              state_d = S_GAP;
              x_d     = 1'b0;
              x_vld_d = 1'b0;
              frame_d = 1'b0;
`else
              x_d     = pattern_q[W-1];
              frame_d = 1'b1;
`endif
            end
          end
        end
      end

`ifdef SEQ_GAP_EN
      S_GAP: begin
        state_d = S_SHIFT;
        x_d     = pattern_q[W-1];
        x_vld_d = 1'b1;
        frame_d = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
        x_d     = 1'b0;
        x_vld_d = 1'b0;
        frame_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      reps_q    <= '0;
      bit_idx_q <= '0;
      x_q       <= 1'b0;
      x_vld_q   <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      reps_q    <= reps_d;
      bit_idx_q <= bit_idx_d;
      x_q       <= x_d;
      x_vld_q   <= x_vld_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  assign x     = x_q;
  assign x_vld = x_vld_q;
  assign frame = frame_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// Directed bench for seq_pattern_gen: scoreboard of expected serial bits plus latency checks.
module tb_seq_pattern_gen;

  localparam int W = 4;
`ifdef SEQ_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] reps;
  logic       ready;
  logic       x, x_vld, frame, busy, done;

  typedef struct packed {
    logic x;
    logic frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_pattern_gen #(.W(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .ready   (ready),
    .x       (x),
    .x_vld   (x_vld),
    .frame   (frame),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_frames(input logic [3:0] pat, input int r);
    exp_t e;
    for (int rep = 0; rep < r; rep++) begin
      for (int b = W - 1; b >= 0; b--) begin
        e.x     = pat[b];
        e.frame = (b == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive one cycle's inputs, score the visible bit, then advance past the next edge.
  task automatic cyc(input logic rdy_in, input logic start_in);
    exp_t e;
    ready = rdy_in;
    start = start_in;
    if (x_vld) begin
      if (exp_q.size() == 0) begin
        chk("spurious_vld", {31'd0, x_vld}, 32'd0);
      end else begin
        e = exp_q[0];
        chk("bit", {30'd0, x, frame}, {30'd0, e.x, e.frame});
        if (rdy_in) void'(exp_q.pop_front());
      end
    end else if (busy) begin
      chk("gap_x", {31'd0, x}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [3:0] pat, input int r,
                           input int stall_at, input int stall_len, input int exp_lat);
    int   n, xfers, stalled;
    logic rdy;
    pattern = pat;
    reps    = r[7:0];
    push_frames(pat, r);
    cyc(1'b1, 1'b1);
    // Scramble the inputs and keep requesting: neither may disturb the frame.
    pattern = ~pat;
    reps    = 8'd7;
    n = 1; xfers = 0; stalled = 0;
    while (!done && n < 200) begin
      rdy = 1'b1;
      if (x_vld && xfers == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      if (x_vld && rdy) xfers++;
      cyc(rdy, 1'b1);
      n++;
    end
    chk(tag, n, exp_lat);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("xvld_at_done", {31'd0, x_vld}, 32'd0);
    cyc(1'b1, 1'b0);
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n, dones;
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    reps    = '0;
    ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", {31'd0, x}, 32'd0);
    chk("rst_xvld", {31'd0, x_vld}, 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);

    // Reset mid-frame on the second bit of 1011.
    pattern = 4'b1011;
    reps    = 8'd2;
    push_frames(4'b1011, 2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("pre_rst_x", {31'd0, x}, 32'd0);
    chk("pre_rst_xvld", {31'd0, x_vld}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_x", {31'd0, x}, 32'd0);
    chk("async_xvld", {31'd0, x_vld}, 32'd0);
    chk("async_frame", {31'd0, frame}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      cyc(1'b1, 1'b0);
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    run_frame("lat_1011x2", 4'b1011, 2, -1, 0, 4 * 2 + GAP + 1);
    run_frame("lat_stall", 4'b1011, 1, 1, 3, 4 + 3 + 1);
    run_frame("lat_reps0", 4'b1011, 0, -1, 0, 1);
    run_frame("lat_0101x3_stall_lsb", 4'b0101, 3, 3, 2, 12 + 2 * GAP + 2 + 1);

    // start held high: back-to-back frames separated only by the done cycle.
    pattern = 4'b0110;
    reps    = 8'd1;
    push_frames(4'b0110, 3);
    n = 0;
    dones = 0;
    while (dones < 3 && n < 100) begin
      cyc(1'b1, 1'b1);
      n++;
      if (done) dones++;
    end
    chk("b2b_cycles", n, 32'd15);
    chk("b2b_dones", dones, 32'd3);
    cyc(1'b1, 1'b0);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    chk("b2b_scoreboard", exp_q.size(), 32'd0);

`ifdef SEQ_GAP_EN
    run_frame("lat_gap_1011x3", 4'b1011, 3, -1, 0, 15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
